// File: rtl/register_file_param_if.sv
// Bundles the read, writeback, allocate and clear-control signals of the
// register file into one connection. The master side drives addresses and
// requests. The slave side, which is the register file, returns read data,
// readiness and clear-sweep status.
interface register_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              rd_ready_1;
    logic              rd_ready_2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_addr;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, clr_req,
        input  rd_data_1, rd_data_2, rd_ready_1, rd_ready_2,
               clr_busy, clr_done
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_data,
               alloc_en, alloc_addr, clr_req,
        output rd_data_1, rd_data_2, rd_ready_1, rd_ready_2,
               clr_busy, clr_done
    );
endinterface

// File: rtl/register_file_param.sv
// Register file with two combinational read ports, one writeback port, and
// per-register pending (scoreboard) bits. Optional features:
//  - register 0 can be hardwired to zero;
//  - a write can be forwarded to a read of the same address in the same cycle.
// A clear request starts a sweep. The sweep zeroes one register per cycle.
// While it runs, the port is busy and ignores writes, allocations and further
// clear requests.
module register_file_param #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 5,
    parameter int              ZERO_REG = 1,
    parameter int              BYPASS   = 1,
    parameter logic [DATA_W-1:0] INIT_R1 = 32'h0000_00A5,
    parameter logic [DATA_W-1:0] INIT_R2 = 32'hFFFF_FF5A
) (
    input  logic                  clk,
    input  logic                  reset,
    register_file_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              busy;
    logic              wr_accept;
    logic              alloc_accept;

    // True when an address refers to the hardwired zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign busy         = (state != IDLE);
    assign bus.clr_busy = busy;
    assign bus.clr_done = (state == DONE);
    assign wr_accept    = bus.wr_en && !busy && !is_zero(bus.wr_addr);
    assign alloc_accept = bus.alloc_en && !busy && !is_zero(bus.alloc_addr);

    // Read port 1: array value, overridden by a same-cycle write or by the zero register.
    always_comb begin
        bus.rd_data_1  = regs[bus.rd_addr_1];
        bus.rd_ready_1 = !pending[bus.rd_addr_1];
        if ((BYPASS != 0) && wr_accept && (bus.wr_addr == bus.rd_addr_1)) begin
            bus.rd_data_1  = bus.wr_data;
            bus.rd_ready_1 = 1'b1;
        end
        if (is_zero(bus.rd_addr_1)) begin
            bus.rd_data_1  = '0;
            bus.rd_ready_1 = 1'b1;
        end
        if (busy) begin
            bus.rd_ready_1 = 1'b0;
        end
    end

    // Read port 2: same selection rules as port 1.
    always_comb begin
        bus.rd_data_2  = regs[bus.rd_addr_2];
        bus.rd_ready_2 = !pending[bus.rd_addr_2];
        if ((BYPASS != 0) && wr_accept && (bus.wr_addr == bus.rd_addr_2)) begin
            bus.rd_data_2  = bus.wr_data;
            bus.rd_ready_2 = 1'b1;
        end
        if (is_zero(bus.rd_addr_2)) begin
            bus.rd_data_2  = '0;
            bus.rd_ready_2 = 1'b1;
        end
        if (busy) begin
            bus.rd_ready_2 = 1'b0;
        end
    end

    // Clear FSM. Sweeps index 0..DEPTH-1, then holds DONE for one cycle.
    // The index stops at DEPTH-1 and is reloaded with 0 on the next start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state <= SWEEP;
                        index <= '0;
                    end
                end
                SWEEP: begin
                    if (index == {ADDR_W{1'b1}}) begin
                        state <= DONE;
                    end else begin
                        index <= index + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Register storage: reset image, sweep zeroing, or an accepted writeback.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            regs[1] <= INIT_R1;
            regs[2] <= INIT_R2;
        end else if (state == SWEEP) begin
            regs[index] <= '0;
        end else if (wr_accept) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Pending bits: a write clears its bit, and an allocation sets its bit.
    // The allocation comes second, so it wins when both target one address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else if (state == SWEEP) begin
            pending[index] <= 1'b0;
        end else begin
            if (wr_accept) begin
                pending[bus.wr_addr] <= 1'b0;
            end
            if (alloc_accept) begin
                pending[bus.alloc_addr] <= 1'b1;
            end
        end
    end
endmodule
